approx_max_stream: RTL and testbench

- Streaming, parametrised successor to our combinational approximate max slices.
- Accepts N_CH operands per beat over a valid/ready stream and reduces them across a frame of beats.
- Compares operands approximately: low APPROX_LSB bits are ignored. Returns the full-precision winning value, its channel index and the frame beat count.
- Sits between operand producers and the BMF-evaluation error-collection logic.

---
 rtl/approx_max_stream_pkg.sv | 25 ++
 rtl/approx_max_stream_if.sv | 59 +++++
 rtl/approx_max_stream_tree.sv | 47 ++++
 rtl/approx_max_stream.sv | 166 ++++++++++++++++
 tb/tb_approx_max_stream.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_max_stream_pkg.sv
// Shared types and helpers for the approximate streaming max reducer.
// Consumers: approx_max_tree, approx_max_stream_if, approx_max_stream.
package approx_max_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Among equal keys inside one beat the lower channel index is kept.
    localparam bit TIE_LOWEST_IDX = 1'b1;

    // Comparison key: operand with its low lsb bits dropped (unsigned).
    function automatic logic [31:0] approx_key(input logic [31:0] value,
                                               input int unsigned lsb);
        return value >> lsb;
    endfunction

endpackage

// File: rtl/approx_max_stream_if.sv
// Beat input stream and frame result stream of approx_max_stream.
// Optional EXACT_SHADOW_EN adds out_exact / out_err to the result side.
interface approx_max_stream_if #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int IDX_W = $clog2(N_CH)
);

    // Both streams: a transfer happens on a rising edge where valid & ready
    // are both high; the source holds valid and payload stable until then,
    // and valid never waits on ready.
    logic                            in_valid;
    logic                            in_ready;
    logic [N_CH*W-1:0]               in_data;
    logic                            in_last;

    logic                            out_valid;
    logic                            out_ready;
    logic [W-1:0]                    out_max;
    logic [IDX_W-1:0]                out_idx;
    logic [approx_max_pkg::CNT_W-1:0] out_cnt;
`ifdef EXACT_SHADOW_EN
    logic [W-1:0]                    out_exact;
    logic [W-1:0]                    out_err;
`endif

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_max,
        input  out_idx,
`ifdef EXACT_SHADOW_EN
        input  out_exact,
        input  out_err,
`endif
        input  out_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_max,
        output out_idx,
`ifdef EXACT_SHADOW_EN
        output out_exact,
        output out_err,
`endif
        output out_cnt
    );

endinterface

// File: rtl/approx_max_stream_tree.sv
// Combinational per-beat max over N_CH channels using a truncated key;
// returns the full-precision winner, its channel and its key.
module approx_max_tree
    import approx_max_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int APPROX_LSB = 2,
    localparam int IDX_W     = $clog2(N_CH),
    localparam int KW        = W - APPROX_LSB
) (
    input  logic [N_CH*W-1:0] data_i,
    output logic [W-1:0]      val_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [KW-1:0]     key_o
);

    logic [W-1:0]     best_val;
    logic [IDX_W-1:0] best_idx;
    logic [KW-1:0]    best_key;
    logic [KW-1:0]    cand_key;
    logic             take;

    // Channels are visited in ascending order, so the tie rule decides
    // whether an equal key may displace an earlier (lower) channel.
    always_comb begin
        best_val = data_i[W-1:0];
        best_idx = '0;
        best_key = KW'(approx_key(32'(data_i[W-1:0]), APPROX_LSB));
        cand_key = '0;
        take     = 1'b0;
        for (int c = 1; c < N_CH; c++) begin
            cand_key = KW'(approx_key(32'(data_i[c*W +: W]), APPROX_LSB));
            take     = TIE_LOWEST_IDX ? (cand_key > best_key) : (cand_key >= best_key);
            if (take) begin
                best_val = data_i[c*W +: W];
                best_idx = IDX_W'(c);
                best_key = cand_key;
            end
        end
    end

    assign val_o = best_val;
    assign idx_o = best_idx;
    assign key_o = best_key;

endmodule

// File: rtl/approx_max_stream.sv
// Frame-wide approximate max over a beat stream: S1 holds the beat winner,
// S2 the running max. EXACT_SHADOW_EN adds an exact-max shadow path.
module approx_max_stream
    import approx_max_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int APPROX_LSB = 2,
    localparam int IDX_W     = $clog2(N_CH),
    localparam int KW        = W - APPROX_LSB
) (
    input  logic                   clk,
    input  logic                   rst_n,
    approx_max_stream_if.slave     stream_if,
    output state_e                 dbg_state_o
);

    state_e           state_q, state_d;
    logic             accept;
    logic             done_hs;

    logic [W-1:0]     tree_val;
    logic [IDX_W-1:0] tree_idx;
    logic [KW-1:0]    tree_key;

    logic             s1_valid_q;
    logic [W-1:0]     s1_val_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic [KW-1:0]    s1_key_q;

    logic [W-1:0]     acc_val_q;
    logic [IDX_W-1:0] acc_idx_q;
    logic [KW-1:0]    acc_key_q;
    logic [CNT_W-1:0] cnt_q;
    logic             first_beat;
    logic             replace;

    assign stream_if.in_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);
    assign accept             = stream_if.in_valid && stream_if.in_ready;
    assign done_hs            = (state_q == ST_DONE) && stream_if.out_ready;

    approx_max_tree #(
        .N_CH       (N_CH),
        .W          (W),
        .APPROX_LSB (APPROX_LSB)
    ) u_tree (
        .data_i (stream_if.in_data),
        .val_o  (tree_val),
        .idx_o  (tree_idx),
        .key_o  (tree_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN lasts until S1 is empty, i.e. S2 has absorbed the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = stream_if.in_last ? ST_DRAIN : ST_ACC;
            ST_ACC:   if (accept && stream_if.in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_valid_q) state_d = ST_DONE;
            ST_DONE:  if (stream_if.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_val_q   <= '0;
            s1_idx_q   <= '0;
            s1_key_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_val_q <= tree_val;
                s1_idx_q <= tree_idx;
                s1_key_q <= tree_key;
            end
        end
    end

    // The count never wraps back to zero, so zero marks an empty frame.
    assign first_beat = (cnt_q == '0);
    assign replace    = first_beat || (s1_key_q > acc_key_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_val_q <= '0;
            acc_idx_q <= '0;
            acc_key_q <= '0;
            cnt_q     <= '0;
        end else if (done_hs) begin
            acc_val_q <= '0;
            acc_idx_q <= '0;
            acc_key_q <= '0;
            cnt_q     <= '0;
        end else if (s1_valid_q) begin
            if (replace) begin
                acc_val_q <= s1_val_q;
                acc_idx_q <= s1_idx_q;
                acc_key_q <= s1_key_q;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign stream_if.out_valid = (state_q == ST_DONE);
    assign stream_if.out_max   = acc_val_q;
    assign stream_if.out_idx   = acc_idx_q;
    assign stream_if.out_cnt   = cnt_q;
    assign dbg_state_o         = state_q;

`ifdef EXACT_SHADOW_EN
    logic [W-1:0]     ex_tree_val;
    logic [IDX_W-1:0] ex_tree_idx;
    logic [W-1:0]     ex_tree_key;
    logic             unused_ex;
    logic [W-1:0]     s1_ex_val_q;
    logic [W-1:0]     acc_ex_q;

    approx_max_tree #(
        .N_CH       (N_CH),
        .W          (W),
        .APPROX_LSB (0)
    ) u_tree_exact (
        .data_i (stream_if.in_data),
        .val_o  (ex_tree_val),
        .idx_o  (ex_tree_idx),
        .key_o  (ex_tree_key)
    );

    // With no dropped bits the key equals the value; only the value is kept.
    assign unused_ex = ^{ex_tree_idx, ex_tree_key};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ex_val_q <= '0;
        end else if (accept) begin
            s1_ex_val_q <= ex_tree_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_ex_q <= '0;
        end else if (done_hs) begin
            acc_ex_q <= '0;
        end else if (s1_valid_q && (first_beat || (s1_ex_val_q > acc_ex_q))) begin
            acc_ex_q <= s1_ex_val_q;
        end
    end

    assign stream_if.out_exact = acc_ex_q;
    assign stream_if.out_err   = acc_ex_q - acc_val_q;
`endif

endmodule

// File: tb/tb_approx_max_stream.sv
// Directed and randomized bench for approx_max_stream: one instance with
// APPROX_LSB=2, one with APPROX_LSB=0; honours EXACT_SHADOW_EN.
module tb_approx_max_stream;
    import approx_max_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    approx_max_stream_if #(.N_CH(4), .W(8)) ifa ();
    approx_max_stream_if #(.N_CH(4), .W(8)) ifb ();
    state_e dbg_a, dbg_b;

    approx_max_stream #(.N_CH(4), .W(8), .APPROX_LSB(2)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .stream_if   (ifa.slave),
        .dbg_state_o (dbg_a)
    );

    approx_max_stream #(.N_CH(4), .W(8), .APPROX_LSB(0)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .stream_if   (ifb.slave),
        .dbg_state_o (dbg_b)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] beat_q[$];
    logic [25:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ifa.in_ready : ifb.in_ready;
    endfunction

    function automatic logic ovalid(input int sel);
        return (sel == 0) ? ifa.out_valid : ifb.out_valid;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] d, input logic l);
        if (sel == 0) begin
            ifa.in_valid = v; ifa.in_data = d; ifa.in_last = l;
        end else begin
            ifb.in_valid = v; ifb.in_data = d; ifb.in_last = l;
        end
    endtask

    task automatic set_oready(input int sel, input logic r);
        if (sel == 0) ifa.out_ready = r;
        else ifb.out_ready = r;
    endtask

    task automatic send_beat(input int sel, input logic [31:0] d, input logic last);
        int guard = 0;
        drive(sel, 1'b1, d, last);
        while (!rdy(sel) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy(sel)) chk("accept_timeout", 32'(rdy(sel)), 1);
        @(negedge clk);
        drive(sel, 1'b0, d, 1'b0);
    endtask

    task automatic wait_valid(input int sel, input string tag);
        int guard = 0;
        while (!ovalid(sel) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!ovalid(sel)) chk({tag, "_valid_timeout"}, 32'(ovalid(sel)), 1);
    endtask

    task automatic check_res(input int sel, input string tag, input int m, input int ix,
                             input int c, input int ex);
        if (sel == 0) begin
            chk({tag, "_max"}, 32'(ifa.out_max), 32'(m));
            chk({tag, "_idx"}, 32'(ifa.out_idx), 32'(ix));
            chk({tag, "_cnt"}, 32'(ifa.out_cnt), 32'(c));
`ifdef EXACT_SHADOW_EN
            chk({tag, "_exact"}, 32'(ifa.out_exact), 32'(ex));
            chk({tag, "_err"}, 32'(ifa.out_err), 32'(ex - m));
`endif
        end else begin
            chk({tag, "_max"}, 32'(ifb.out_max), 32'(m));
            chk({tag, "_idx"}, 32'(ifb.out_idx), 32'(ix));
            chk({tag, "_cnt"}, 32'(ifb.out_cnt), 32'(c));
`ifdef EXACT_SHADOW_EN
            chk({tag, "_exact"}, 32'(ifb.out_exact), 32'(ex));
            chk({tag, "_err"}, 32'(ifb.out_err), 32'(ex - m));
`endif
        end
    endtask

    task automatic handshake(input int sel, input string tag);
        set_oready(sel, 1'b1);
        @(negedge clk);
        set_oready(sel, 1'b0);
        chk({tag, "_valid_clear"}, 32'(ovalid(sel)), 0);
    endtask

    // Reference: scan beats in arrival order and channels in ascending order,
    // replacing only on a strictly larger key; exact max is the plain maximum.
    function automatic logic [25:0] model_calc(input int lsb);
        int best_key = -1;
        int m = 0, ix = 0, ex = 0, c;
        logic [31:0] bt;
        for (int b = 0; b < beat_q.size(); b++) begin
            bt = beat_q[b];
            for (int ch = 0; ch < 4; ch++) begin
                int v = int'(bt[ch*8 +: 8]);
                if ((v >> lsb) > best_key) begin
                    best_key = v >> lsb; m = v; ix = ch;
                end
                if (v > ex) ex = v;
            end
        end
        c = (beat_q.size() > 255) ? 255 : beat_q.size();
        return {8'(m), 2'(ix), 8'(c), 8'(ex)};
    endfunction

    task automatic check_model(input int sel, input string tag);
        logic [25:0] r;
        r = exp_q.pop_front();
        check_res(sel, tag, int'(r[25:18]), int'(r[17:16]), int'(r[15:8]), int'(r[7:0]));
    endtask

    function automatic logic [31:0] rand_beat();
        logic [31:0] d;
        for (int ch = 0; ch < 4; ch++)
            d[ch*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(196, 207))
                                                        : 8'($urandom_range(0, 255));
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        set_oready(0, 1'b0);
        set_oready(1, 1'b0);
        repeat (3) @(negedge clk);

        // Reset values while reset is held, then ready after release.
        check_res(0, "rst", 0, 0, 0, 0);
        chk("rst_valid", 32'(ifa.out_valid), 0);
        chk("rst_state", 32'(dbg_a), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_a", 32'(ifa.in_ready), 1);
        chk("rst_in_ready_b", 32'(ifb.in_ready), 1);

        // Single beat plus two-edge latency.
        send_beat(0, pack4(10, 200, 50, 199), 1'b1);
        chk("lat_t1", 32'(ifa.out_valid), 0);
        @(negedge clk);
        chk("lat_t2", 32'(ifa.out_valid), 0);
        @(negedge clk);
        chk("lat_t3", 32'(ifa.out_valid), 1);
        check_res(0, "single", 200, 1, 1, 200);
        handshake(0, "single");

        // Equal keys: lowest channel wins on the approximate instance.
        send_beat(0, pack4(201, 203, 0, 0), 1'b1);
        wait_valid(0, "tie_a");
        check_res(0, "tie_a", 201, 0, 1, 203);
        handshake(0, "tie_a");
        send_beat(1, pack4(201, 203, 0, 0), 1'b1);
        wait_valid(1, "tie_b");
        check_res(1, "tie_b", 203, 1, 1, 203);
        handshake(1, "tie_b");

        // Three beats: earlier beat keeps an equal key, later larger key wins.
        send_beat(0, pack4(5, 6, 100, 7), 1'b0);
        send_beat(0, pack4(1, 2, 3, 102), 1'b0);
        @(negedge clk);
        chk("frame3_mid_max", 32'(ifa.out_max), 100);
        chk("frame3_mid_idx", 32'(ifa.out_idx), 2);
        send_beat(0, pack4(120, 4, 5, 6), 1'b1);
        wait_valid(0, "frame3");
        check_res(0, "frame3", 120, 0, 3, 120);
        handshake(0, "frame3");

        // Result held 5 cycles with a blocked beat offered meanwhile.
        send_beat(0, pack4(10, 20, 30, 40), 1'b1);
        wait_valid(0, "hold");
        drive(0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_res(0, "hold", 40, 3, 1, 40);
            chk("hold_in_ready", 32'(ifa.in_ready), 0);
            chk("hold_valid", 32'(ifa.out_valid), 1);
            @(negedge clk);
        end
        drive(0, 1'b0, '0, 1'b0);
        handshake(0, "hold");
        chk("hold_ready_after", 32'(ifa.in_ready), 1);
        send_beat(0, pack4(1, 2, 3, 4), 1'b1);
        wait_valid(0, "after_hold");
        check_res(0, "after_hold", 4, 3, 1, 4);
        handshake(0, "after_hold");

        // Mid-frame asynchronous reset discards the partial frame.
        send_beat(0, pack4(250, 1, 1, 1), 1'b0);
        send_beat(0, pack4(1, 1, 1, 251), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(ifa.out_valid), 0);
        check_res(0, "mrst", 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send_beat(0, pack4(7, 3, 1, 0), 1'b1);
        wait_valid(0, "post_rst");
        check_res(0, "post_rst", 7, 0, 1, 7);
        handshake(0, "post_rst");

        // Randomized frames against the reference model.
        for (int f = 0; f < 16; f++) begin
            int sel = (f % 4 == 3) ? 1 : 0;
            int len = $urandom_range(1, 5);
            logic [31:0] d;
            for (int b = 0; b < len; b++) begin
                d = rand_beat();
                beat_q.push_back(d);
                send_beat(sel, d, b == len - 1);
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            exp_q.push_back(model_calc(sel == 1 ? 0 : 2));
            beat_q.delete();
            wait_valid(sel, "rnd");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_model(sel, "rnd");
            handshake(sel, "rnd");
        end

        // Long frame saturates the beat count.
        for (int b = 0; b < 300; b++) begin
            logic [31:0] d;
            d = rand_beat();
            beat_q.push_back(d);
            send_beat(1, d, b == 299);
        end
        exp_q.push_back(model_calc(0));
        beat_q.delete();
        wait_valid(1, "sat");
        check_model(1, "sat");
        handshake(1, "sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
